// File: rtl/reg_dump_pkg.sv
// Shared constants, register indices and FSM states for the
// register-dump scanner.
package reg_dump_pkg;

    localparam int NUM_REGS = 11;
    localparam int REG_W    = 16;
    localparam int IDX_W    = 4;

    localparam logic [IDX_W-1:0] IDX_R0 = 4'd0;
    localparam logic [IDX_W-1:0] IDX_R1 = 4'd1;
    localparam logic [IDX_W-1:0] IDX_R2 = 4'd2;
    localparam logic [IDX_W-1:0] IDX_R3 = 4'd3;
    localparam logic [IDX_W-1:0] IDX_R4 = 4'd4;
    localparam logic [IDX_W-1:0] IDX_R5 = 4'd5;
    localparam logic [IDX_W-1:0] IDX_R6 = 4'd6;
    localparam logic [IDX_W-1:0] IDX_R7 = 4'd7;
    localparam logic [IDX_W-1:0] IDX_SP = 4'd8;
    localparam logic [IDX_W-1:0] IDX_IH = 4'd9;
    localparam logic [IDX_W-1:0] IDX_T  = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/reg_snapshot_mux.sv
// Selects one 16-bit register word out of the packed debug-bus image.
// Word 0 (R0) sits in the most significant slice.
module reg_snapshot_mux #(
    parameter int NUM_REGS = 11,
    parameter int REG_W    = 16
) (
    input  logic [NUM_REGS*REG_W-1:0] snap,
    input  logic [3:0]                sel,
    output logic [REG_W-1:0]          word
);

    // Constant-slice decode keeps out-of-range selects at zero
    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == 4'(i)) begin
                word = snap[(NUM_REGS-1-i)*REG_W +: REG_W];
            end
        end
    end

endmodule

// File: rtl/reg_dump_scanner.sv
// Snapshots the register-file debug bus and streams it one word per beat.
// Optional REG_DUMP_CHANGED_ONLY_EN skips words unchanged since last dump.
module reg_dump_scanner #(
    parameter int NUM_REGS = reg_dump_pkg::NUM_REGS,
    parameter int REG_W    = reg_dump_pkg::REG_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic [NUM_REGS*REG_W-1:0] regSnapshot,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [3:0]                outIndex,
    output logic [REG_W-1:0]          outData,
    output logic                      busy,
    output logic                      done
);

    import reg_dump_pkg::*;

    localparam int SNAP_W = NUM_REGS * REG_W;
    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    state_t            state;
    state_t            stateNext;
    logic [3:0]        idx;
    logic [3:0]        idxNext;
    logic [SNAP_W-1:0] snapshot;
    logic              capture;
    logic              skip;
    logic [REG_W-1:0]  curWord;

    reg_snapshot_mux #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W)
    ) uCurMux (
        .snap (snapshot),
        .sel  (idx),
        .word (curWord)
    );

`ifdef REG_DUMP_CHANGED_ONLY_EN
    logic [SNAP_W-1:0] prevSnap;
    logic              firstDump;
    logic [REG_W-1:0]  prevWord;

    reg_snapshot_mux #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W)
    ) uPrevMux (
        .snap (prevSnap),
        .sel  (idx),
        .word (prevWord)
    );

    assign skip = !firstDump && (curWord == prevWord);

    // Remember the completed dump as the reference for the next one
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prevSnap  <= '0;
            firstDump <= 1'b1;
        end else if (state == FIN) begin
            prevSnap  <= snapshot;
            firstDump <= 1'b0;
        end
    end
`else
    assign skip = 1'b0;
`endif

    // State, beat index and the frozen register image
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= '0;
            snapshot <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
            if (capture) begin
                snapshot <= regSnapshot;
            end
        end
    end

    // Next state, index advance and beat outputs
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        capture   = 1'b0;
        outValid  = 1'b0;
        outIndex  = '0;
        outData   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = SEND;
                    idxNext   = '0;
                    capture   = 1'b1;
                end
            end
            SEND: begin
                busy     = 1'b1;
                outValid = !skip;
                if (!skip) begin
                    outIndex = idx;
                    outData  = curWord;
                end
                if (skip || outReady) begin
                    if (idx == LAST_IDX) begin
                        stateNext = FIN;
                    end else begin
                        idxNext = idx + 4'd1;
                    end
                end
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Self-checking bench for reg_dump_scanner: vector table, hand-written
// corner cases and randomized dumps against a word-list model.
module tb_reg_dump_scanner;

    localparam int N = 11;
    localparam int W = 16;

    logic           CLK = 1'b0;
    logic           RST;
    logic           start;
    logic [N*W-1:0] regSnapshot;
    logic           outValid;
    logic           outReady;
    logic [3:0]     outIndex;
    logic [W-1:0]   outData;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    logic [15:0] prevWords [N];
    bit          modelFirst = 1'b1;

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        int          stallIdx;
        int          stallLen;
        int          expDone;
    } vec_t;

    vec_t vecs [4];

    always #5 CLK = ~CLK;

    reg_dump_scanner dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .regSnapshot (regSnapshot),
        .outValid    (outValid),
        .outReady    (outReady),
        .outIndex    (outIndex),
        .outData     (outData),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input logic [15:0] w [N]);
        logic [N*W-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            p[(N-1-i)*W +: W] = w[i];
        end
        return p;
    endfunction

    task automatic doReset();
        RST = 1'b1;
        modelFirst = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // One dump. mode 0: ready high except a stall of stallLen cycles at
    // stallIdx; mode 1: random ready. Called #1 after a posedge, DUT idle.
    task automatic runDump(input logic [15:0] words [N], input int mode,
                           input int stallIdx, input int stallLen,
                           input bit corrupt, input bit startMid,
                           output int doneCycle, output int beats);
        bit emit [N];
        int p;
        int c;
        int stalled;
        bit rdy;
        bit pulsed;
        bit fin;
        for (int i = 0; i < N; i++) begin
            emit[i] = 1'b1;
`ifdef REG_DUMP_CHANGED_ONLY_EN
            emit[i] = modelFirst || (words[i] != prevWords[i]);
`endif
        end
        regSnapshot = pack(words);
        start = 1'b1;
        outReady = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        p = 0;
        c = 1;
        stalled = 0;
        beats = 0;
        doneCycle = -1;
        pulsed = 1'b0;
        fin = 1'b0;
        while (!fin && c < 400) begin
            if (corrupt && c == 1) regSnapshot = '1;
            start = 1'b0;
            if (startMid && !pulsed && p == 6) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (p < N) begin
                if (mode == 0) rdy = !(p == stallIdx && stalled < stallLen);
                else rdy = ($urandom % 4) != 0;
                outReady = rdy;
                @(negedge CLK);
                chk("busy_send", busy, 1);
                chk("done_early", done, 0);
                chk("valid", outValid, emit[p]);
                if (emit[p]) begin
                    chk("index", outIndex, 32'(p));
                    chk("data", outData, words[p]);
                    if (rdy) begin
                        p++;
                        beats++;
                    end else begin
                        stalled++;
                    end
                end else begin
                    p++;
                end
            end else begin
                outReady = 1'($urandom % 2);
                @(negedge CLK);
                chk("done_pulse", done, 1);
                chk("busy_fin", busy, 1);
                chk("valid_fin", outValid, 0);
                doneCycle = c;
                fin = 1'b1;
            end
            @(posedge CLK);
            #1;
            c++;
        end
        start = 1'b0;
        if (!fin) begin
            errors++;
            $display("FAIL timeout: dump not done after %0d cycles", c);
        end
        @(negedge CLK);
        chk("done_single", done, 0);
        chk("busy_after", busy, 0);
        chk("valid_after", outValid, 0);
        if (startMid) begin
            @(negedge CLK);
            chk("no_restart", busy, 0);
        end
        @(posedge CLK);
        #1;
        prevWords = words;
        modelFirst = 1'b0;
    endtask

    initial begin
        logic [15:0] w [N];
        int dc;
        int nb;

        vecs[0] = '{16'h1000, 16'h0001, -1, 0, 12};
        vecs[1] = '{16'h1000, 16'h0001,  3, 5, 17};
        vecs[2] = '{16'hA5A5, 16'h1111,  0, 2, 14};
        vecs[3] = '{16'hFFFF, 16'hFFFE, 10, 3, 15};

        for (int i = 0; i < N; i++) prevWords[i] = '0;
        RST = 1'b1;
        start = 1'b0;
        outReady = 1'b0;
        regSnapshot = {6{$urandom}};
        #12;
        chk("rst_valid", outValid, 0);
        chk("rst_index", outIndex, 0);
        chk("rst_data", outData, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int v = 0; v < 4; v++) begin
            doReset();
            for (int i = 0; i < N; i++) w[i] = vecs[v].base + vecs[v].step * 16'(i);
            runDump(w, 0, vecs[v].stallIdx, vecs[v].stallLen, 0, 0, dc, nb);
            chk("vec_done_cycle", dc, vecs[v].expDone);
            chk("vec_beats", nb, N);
        end

        doReset();
        for (int i = 0; i < N; i++) w[i] = 16'h1000 + 16'(i);
        runDump(w, 0, -1, 0, 1, 0, dc, nb);
        chk("coherent_done", dc, 12);

        doReset();
        runDump(w, 0, -1, 0, 0, 1, dc, nb);
        chk("startmid_done", dc, 12);
        chk("startmid_beats", nb, N);

        doReset();
        regSnapshot = pack(w);
        start = 1'b1;
        outReady = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        chk("mid_index", outIndex, 4);
        chk("mid_data", outData, 16'h1004);
        #1;
        RST = 1'b1;
        #1;
        chk("rstmid_valid", outValid, 0);
        chk("rstmid_index", outIndex, 0);
        chk("rstmid_data", outData, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        repeat (3) begin
            @(negedge CLK);
            chk("rstmid_nodone", done, 0);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        modelFirst = 1'b1;
        runDump(w, 0, -1, 0, 0, 0, dc, nb);
        chk("after_rst_beats", nb, N);
        chk("after_rst_done", dc, 12);

`ifdef REG_DUMP_CHANGED_ONLY_EN
        doReset();
        runDump(w, 0, -1, 0, 0, 0, dc, nb);
        chk("co_first_beats", nb, N);
        w[8] = 16'hBEEF;
        runDump(w, 0, -1, 0, 0, 0, dc, nb);
        chk("co_sp_beats", nb, 1);
        runDump(w, 0, -1, 0, 0, 0, dc, nb);
        chk("co_none_beats", nb, 0);
        chk("co_none_done", dc, 12);
`endif

        doReset();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom % 3 == 0) w[i] = prevWords[i];
                else w[i] = 16'($urandom);
            end
            runDump(w, 1, -1, 0, 1'($urandom % 2), 0, dc, nb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_scanner.md
# reg_dump_scanner

Read-side consumer of the register file's 176-bit debug bus. On a start request it snapshots all eleven architectural registers (R0–R7, SP, IH, T) in one cycle. It then streams them one 16-bit word per beat over a valid/ready interface to a display or UART driver. The CPU keeps running meanwhile, so each dump is a coherent single-cycle image.

## Interface
Parameters:
- NUM_REGS, 11, number of 16-bit words in the debug bus
- REG_W, 16, register width in bits

Ports:
- CLK  in  1  single clock; all state updates on posedge
- RST  in  1  asynchronous, active-high reset
- start  in  1  dump request; sampled only in IDLE
- regSnapshot  in  NUM_REGS*REG_W (176)  debug bus; word i occupies bits [175-16i : 160-16i]. Mapping: i=0 is R0, i=7 is R7, 8 is SP, 9 is IH, 10 is T.
- outValid  out  1  beat valid
- outReady  in  1  sink accepts beat
- outIndex  out  4  register index of current beat (0–10)
- outData  out  16  register value of current beat
- busy  out  1  high from the capture edge until done
- done  out  1  one-cycle pulse after last beat

## Operation
- States:
  - IDLE: waiting for a request.
  - SEND: streaming beats.
  - FIN: one-cycle completion state.
- IDLE → SEND on start=1:
  - the same edge latches regSnapshot into the snapshot register;
  - idx ← 0;
  - busy ← 1.
- SEND:
  - outValid=1;
  - outIndex=idx;
  - outData=snapshot word idx.
  - A transfer occurs on an edge where outValid and outReady are both high.
  - On a transfer: if idx==NUM_REGS-1, go to FIN; otherwise idx←idx+1.
- FIN: done=1 for exactly one cycle. busy←0, then → IDLE.
- start is ignored in SEND and FIN; requests are not queued.
- start held continuously produces back-to-back dumps, with one IDLE cycle between them.
- outReady while outValid=0 has no effect.
- idx never exceeds NUM_REGS-1 and never wraps.
- Once captured, the snapshot register changes only at the next capture. regSnapshot changes during a dump do not affect the output.

## Timing
- Reset values:
  - state=IDLE, idx=0
  - outValid=0, outIndex=0, outData=0
  - busy=0, done=0
  - snapshot=0
- Latency: start sampled at edge k → outValid=1 and busy=1 from edge k (visible in cycle k+1).
- With outReady tied high:
  - beats occupy cycles k+1…k+11;
  - done pulses in cycle k+12;
  - busy falls at edge k+12.
- outIndex and outData are held stable while outValid=1 and outReady=0.
- RST mid-dump: immediate return to reset values. The partial dump is discarded and done is not pulsed.

## Configuration
- Macro REG_DUMP_CHANGED_ONLY_EN.
- Absent: every dump emits all NUM_REGS beats.
- Present:
  - adds a prev-snapshot register and a firstDump flag (set by RST);
  - in SEND, an index whose word equals the prev word (and firstDump=0) is skipped: outValid=0 for one cycle, idx advances;
  - the last index, if skipped, goes to FIN;
  - at FIN, prev←snapshot and firstDump←0;
  - a dump with no changes runs 11 skip cycles, then pulses done with zero beats.

## Structure
- Package reg_dump_pkg holds:
  - NUM_REGS, REG_W;
  - index constants IDX_R0…IDX_R7, IDX_SP, IDX_IH, IDX_T;
  - the state enum (IDLE, SEND, FIN).
- Sub-module reg_snapshot_mux: combinational select of word idx from the 176-bit snapshot, using the bit mapping above. It is shared by the output path and the changed-only compare.

## Test plan
- Capture ordering: drive regSnapshot words 0x1000+i (R0=0x1000…T=0x100A), pulse start, outReady=1 → 11 beats with outIndex 0..10, outData 0x1000..0x100A. done pulses in cycle 12.
- Snapshot coherency: change regSnapshot to all 0xFFFF one cycle after start → every beat still shows the original 0x1000+i values.
- Backpressure: outReady=0 for 5 cycles at idx=3 → outIndex=3 and outData=0x1003 held stable with outValid=1. Completion is delayed by exactly 5 cycles.
- start during busy: pulse start at idx=6 → no restart, 11 beats total, a single done pulse.
- Reset mid-dump: assert RST at idx=4 → all outputs return to 0 and no done pulse. A new start then produces a full dump from idx 0.
- With REG_DUMP_CHANGED_ONLY_EN:
  - first dump emits all 11 beats;
  - a second dump after changing only SP to 0xBEEF emits one beat, outIndex=8, outData=0xBEEF;
  - a third dump with no changes emits zero beats, then done.
